// File: rtl/alu.sv
// rtl/alu.sv - registered two-operand ALU with carry/overflow/sign/zero flags
// and a tri-state result bus.
module alu #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             OE,
    input  logic [3:0]       OPCODE,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic             CF,
    output logic             OF,
    output logic             SF,
    output logic             ZF
);

    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_AND   = 4'b0100;
    localparam logic [3:0] OP_OR    = 4'b0101;
    localparam logic [3:0] OP_XOR   = 4'b0110;
    localparam logic [3:0] OP_NOT_A = 4'b0111;

    logic [WIDTH-1:0] res_d, res_q;
    logic             cf_d, cf_q;
    logic             of_d, of_q;
    logic             sf_d, sf_q;
    logic             zf_d, zf_q;
    logic [WIDTH:0]   ext;

    always_comb begin
        ext   = '0;
        res_d = '0;
        cf_d  = 1'b0;
        of_d  = 1'b0;
        case (OPCODE)
            OP_ADD: begin
                ext   = {1'b0, A} + {1'b0, B};
                res_d = ext[WIDTH-1:0];
                cf_d  = ext[WIDTH];
                of_d  = (A[WIDTH-1] == B[WIDTH-1]) && (res_d[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                // Bit WIDTH of the extended difference is set exactly when A < B unsigned.
                ext   = {1'b0, A} - {1'b0, B};
                res_d = ext[WIDTH-1:0];
                cf_d  = ext[WIDTH];
                of_d  = (A[WIDTH-1] != B[WIDTH-1]) && (res_d[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:   res_d = A & B;
            OP_OR:    res_d = A | B;
            OP_XOR:   res_d = A ^ B;
            OP_NOT_A: res_d = ~A;
            default:  res_d = '0;
        endcase
        sf_d = res_d[WIDTH-1];
        zf_d = (res_d == '0);
    end

    // ZF is held in its own register so that reset can clear it alongside a zero result.
    always_ff @(posedge CLK) begin
        if (RST) begin
            res_q <= '0;
            cf_q  <= 1'b0;
            of_q  <= 1'b0;
            sf_q  <= 1'b0;
            zf_q  <= 1'b0;
        end else if (EN) begin
            res_q <= res_d;
            cf_q  <= cf_d;
            of_q  <= of_d;
            sf_q  <= sf_d;
            zf_q  <= zf_d;
        end
    end

    assign ALU_OUT = OE ? res_q : {WIDTH{1'bz}};
    assign CF      = cf_q;
    assign OF      = of_q;
    assign SF      = sf_q;
    assign ZF      = zf_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - table-driven scoreboard bench for the registered ALU.
module tb_alu;

    logic       clk;
    logic       rst;
    logic       en;
    logic       oe;
    logic [3:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
    wire  [7:0] alu_out;
    logic       cf, of_flag, sf, zf;

    int errors = 0;
    int checks = 0;

    logic [11:0] exp_q[$];

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       cf;
        logic       of;
        logic       sf;
        logic       zf;
    } vec_t;

    vec_t vecs[19];

    alu #(.WIDTH(8)) dut (
        .CLK    (clk),
        .RST    (rst),
        .EN     (en),
        .OE     (oe),
        .OPCODE (opcode),
        .A      (a),
        .B      (b),
        .ALU_OUT(alu_out),
        .CF     (cf),
        .OF     (of_flag),
        .SF     (sf),
        .ZF     (zf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic expect_out(input logic [7:0] res, input logic c, input logic o,
                              input logic s, input logic z);
        exp_q.push_back({res, c, o, s, z});
    endtask

    task automatic step(input string name);
        logic [11:0] exp;
        logic [11:0] act;
        @(posedge clk);
        @(negedge clk);
        checks++;
        act = {alu_out, cf, of_flag, sf, zf};
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got out=%h cf/of/sf/zf=%b", name, act[11:4], act[3:0]);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                errors++;
                $display("FAIL %s: got out=%h cf/of/sf/zf=%b, want out=%h cf/of/sf/zf=%b",
                         name, act[11:4], act[3:0], exp[11:4], exp[3:0]);
            end
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv);
        opcode = op;
        a      = av;
        b      = bv;
    endtask

    initial begin
        //           op       a      b      res    cf    of    sf    zf
        vecs[0]  = '{4'b0010, 8'h03, 8'h01, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{4'b0010, 8'h0F, 8'h0F, 8'h1E, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{4'b0010, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{4'b0010, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{4'b0010, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{4'b0010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{4'b0011, 8'h03, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{4'b0011, 8'h0F, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{4'b0011, 8'h03, 8'hF0, 8'h13, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{4'b0011, 8'hAA, 8'h55, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{4'b0011, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{4'b0100, 8'hAA, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{4'b0101, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{4'b0110, 8'h0F, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{4'b0110, 8'h03, 8'hF0, 8'hF3, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{4'b0111, 8'h03, 8'h00, 8'hFC, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{4'b0111, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{4'b1000, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{4'b0011, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        en  = 1'b1;
        oe  = 1'b1;
        drive(4'b0010, 8'h11, 8'h22);
        expect_out(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step("reset");

        rst = 1'b0;
        en  = 1'b0;
        drive(4'b0010, 8'h03, 8'h01);
        expect_out(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step("disabled_after_reset");

        oe = 1'b0;
        #1;
        checks++;
        if (alu_out !== {8{1'bz}} || {cf, of_flag, sf, zf} !== 4'b0000) begin
            errors++;
            $display("FAIL oe_low: got out=%h flags=%b, want out=zz flags=0000", alu_out, {cf, of_flag, sf, zf});
        end
        oe = 1'b1;
        en = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            expect_out(vecs[i].res, vecs[i].cf, vecs[i].of, vecs[i].sf, vecs[i].zf);
            step($sformatf("vec%0d_op%b_%h_%h", i, vecs[i].op, vecs[i].a, vecs[i].b));
        end

        drive(4'b0010, 8'h03, 8'h01);
        expect_out(8'h04, 1'b0, 1'b0, 1'b0, 1'b0);
        step("hold_load");
        en = 1'b0;
        drive(4'b0010, 8'hAA, 8'h01);
        expect_out(8'h04, 1'b0, 1'b0, 1'b0, 1'b0);
        step("hold_en_low");
        drive(4'b0111, 8'h00, 8'h00);
        expect_out(8'h04, 1'b0, 1'b0, 1'b0, 1'b0);
        step("hold_opcode_change");

        oe = 1'b0;
        #1;
        checks++;
        if (alu_out !== {8{1'bz}}) begin
            errors++;
            $display("FAIL oe_low_hold: got out=%h, want out=zz", alu_out);
        end
        oe = 1'b1;
        #1;
        checks++;
        if (alu_out !== 8'h04) begin
            errors++;
            $display("FAIL oe_high_again: got out=%h, want out=04", alu_out);
        end

        en = 1'b1;
        drive(4'b0111, 8'h03, 8'h00);
        expect_out(8'hFC, 1'b0, 1'b0, 1'b1, 1'b0);
        step("pre_reset_load");
        rst = 1'b1;
        drive(4'b0010, 8'hFF, 8'hFF);
        expect_out(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step("reset_mid_stream");
        rst = 1'b0;
        drive(4'b0010, 8'h00, 8'h00);
        expect_out(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        step("resume_after_reset");
        drive(4'b0010, 8'hFF, 8'hFF);
        expect_out(8'hFE, 1'b1, 1'b0, 1'b1, 1'b0);
        step("resume_carry");

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Registered, parameterized two-operand ALU: add, subtract, AND, OR, XOR and NOT-A, with carry, overflow, sign and zero flags.
- Operands are two's-complement signed. The result sits in an internal register and is driven onto a tri-state output bus under output-enable control.
- Intended as the execution unit of a small datapath sharing a result bus.

Parameters:
- WIDTH, 8, operand and result width in bits (minimum 2).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous active-high reset.
- EN  input  1  capture enable; when high, the result register and flags update each rising edge.
- OE  input  1  output enable for the ALU_OUT bus.
- OPCODE  input  4  operation select.
- A  input  WIDTH  signed operand A.
- B  input  WIDTH  signed operand B.
- ALU_OUT  output  WIDTH  signed result; high-impedance when OE=0.
- CF  output  1  carry/borrow flag (registered).
- OF  output  1  signed overflow flag (registered).
- SF  output  1  sign flag, equal to the MSB of the registered result.
- ZF  output  1  zero flag, high when the registered result is all zeros.

Behaviour:
- Opcodes:
  - 4'b0010 ADD: R = A+B.
  - 4'b0011 SUB: R = A-B.
  - 4'b0100 AND: R = A&B.
  - 4'b0101 OR: R = A|B.
  - 4'b0110 XOR: R = A^B.
  - 4'b0111 NOT_A: R = ~A.
  - Every other opcode: R = 0, CF = 0, OF = 0.
- Combinational next-result R is computed from the current A, B and OPCODE. All results are truncated to WIDTH bits (wrap-around).
- ADD flags:
  - CF = carry out of the unsigned WIDTH-bit sum.
  - OF = 1 when A and B have the same sign and R's sign differs from it.
- SUB flags:
  - CF = borrow, i.e. 1 when unsigned A < unsigned B.
  - OF = 1 when A and B have different signs and R's sign differs from A's.
- Logic ops and NOT_A: CF = 0, OF = 0.
- SF = R[WIDTH-1] and ZF = (R == 0) for every opcode, including undefined opcodes (which give ZF = 1, SF = 0).
- Register update on the rising CLK edge, evaluated in priority order:
  - RST=1: result register = 0; CF, OF, SF, ZF all = 0. RST overrides EN, and the reset value of every flag is 0, ZF included.
  - RST=0, EN=1: result register and all four flags load R and its flags.
  - RST=0, EN=0: result register and flags hold their values.
- Latency: one cycle. Operands presented before edge N appear on ALU_OUT and the flags after edge N.
- Output enable:
  - ALU_OUT = result register when OE=1, all-Z when OE=0.
  - OE is combinational, with no clock delay.
  - The flags are always driven, regardless of OE.
- Operand or opcode changes while EN=0 have no effect on the outputs.
- Reset asserted mid-stream clears state on the next edge. Operation resumes on the first edge with RST=0 and EN=1.

Test Plan:
- Reset and disable: RST=1 for one edge -> ALU_OUT=0, all flags 0. Then EN=0 with A=3, B=1, ADD -> ALU_OUT stays 0. Then OE=0 -> ALU_OUT=Z while flags remain driven.
- ADD (WIDTH=8, EN=OE=1): results one cycle after the inputs.
  - 3+1 -> 4, CF=OF=SF=ZF=0.
  - 0x0F+0x0F -> 0x1E.
  - 0xAA+0x55 -> 0xFF, SF=1, CF=0.
  - 0xFF+0xFF -> 0xFE, CF=1, OF=0, SF=1.
  - 0+0 -> 0, ZF=1.
  - 0x7F+0x01 -> 0x80, OF=1, SF=1.
- SUB:
  - 3-1 -> 2.
  - 0x0F-0x0F -> 0, ZF=1, CF=0.
  - 0x03-0xF0 -> 0x13, CF=1, OF=0.
  - 0xAA-0x55 -> 0x55, OF=1, CF=0.
  - 0x80-0x01 -> 0x7F, OF=1.
- Logic ops:
  - AND 0xAA&0x55 -> 0x00, ZF=1.
  - OR 0xAA|0x55 -> 0xFF, SF=1.
  - XOR 0x0F^0x0F -> 0, ZF=1.
  - XOR 0x03^0xF0 -> 0xF3.
  - CF=OF=0 throughout.
- NOT_A and undefined opcode:
  - NOT_A A=0x03 -> 0xFC, SF=1.
  - NOT_A A=0xFF -> 0x00, ZF=1.
  - OPCODE=4'b1000 with A=0xFF, B=0xFF -> 0x00, ZF=1, CF=OF=SF=0.
- Hold and reset mid-operation:
  - After ADD 3+1, drop EN and change A to 0xAA -> ALU_OUT stays 4.
  - Assert RST while EN=1 -> next edge ALU_OUT=0, flags 0.
